// File: rtl/dsm_rx_demod_if.sv
// Bus between the delta-sigma symbol source and the receive demodulator:
// the 3-level pwm symbol stream going in, decimated baseband samples coming out.
interface dsm_rx_demod_if #(
    parameter int OUT_W = 20
);
    logic [1:0]              pwm;
    logic signed [OUT_W-1:0] vout;
    logic                    vout_valid;
    logic                    code_err;

    modport master (
        output pwm,
        input  vout,
        input  vout_valid,
        input  code_err
    );

    modport slave (
        input  pwm,
        output vout,
        output vout_valid,
        output code_err
    );
endinterface

// File: rtl/dsm_rx_demod.sv
// Receive demodulator: decodes the 3-level symbol stream, mixes it down with
// the fs/4 LO and recovers baseband through a 3rd-order CIC decimator (gain R^3).
module dsm_rx_demod #(
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_W      = 20
) (
    input  logic           clock,
    input  logic           reset,
    dsm_rx_demod_if.slave  bus
);
    localparam logic [DECIM_LOG2-1:0] DECIM_ONE = DECIM_LOG2'(1);
    localparam logic [DECIM_LOG2-1:0] DECIM_MAX = '1;

    logic [1:0]              lo_cnt;
    logic [DECIM_LOG2-1:0]   decim_cnt;
    logic signed [1:0]       sym;
    logic signed [1:0]       mix_next;
    logic signed [1:0]       mix_r;
    logic signed [OUT_W-1:0] mix_ext;
    logic                    illegal;
    logic                    strobe;

    logic signed [OUT_W-1:0] int1, int2, int3;
    logic signed [OUT_W-1:0] comb_in, comb1, comb2, comb3;
    logic signed [OUT_W-1:0] prev1, prev2, prev3;
    logic                    valid0, valid1, valid2, valid3;

    // Code 2'b11 carries no energy; it only raises code_err one cycle later.
    always_comb begin
        sym      = 2'sb00;
        mix_next = 2'sb00;
        illegal  = 1'b0;
        case (bus.pwm)
            2'b01:   sym = 2'sb01;
            2'b10:   sym = 2'sb11;
            2'b11:   illegal = 1'b1;
            default: sym = 2'sb00;
        endcase
        case (lo_cnt)
            2'd0:    mix_next = sym;
            2'd2:    mix_next = -sym;
            default: mix_next = 2'sb00;
        endcase
    end

    assign mix_ext = {{(OUT_W-2){mix_r[1]}}, mix_r};
    assign strobe  = (decim_cnt == DECIM_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            lo_cnt       <= 2'd0;
            decim_cnt    <= '0;
            mix_r        <= 2'sb00;
            bus.code_err <= 1'b0;
        end else begin
            lo_cnt       <= lo_cnt + 2'd1;
            decim_cnt    <= decim_cnt + DECIM_ONE;
            mix_r        <= mix_next;
            bus.code_err <= illegal;
        end
    end

    // Integrators wrap modulo 2^OUT_W; the combs undo the wrap exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            int1 <= '0;
            int2 <= '0;
            int3 <= '0;
        end else begin
            int1 <= int1 + mix_ext;
            int2 <= int2 + int1;
            int3 <= int3 + int2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            comb_in <= '0;
            valid0  <= 1'b0;
        end else begin
            valid0 <= strobe;
            if (strobe) begin
                comb_in <= int3;
            end
        end
    end

    // Each comb stage runs one clock behind the previous, advancing only on
    // the decimated sample, so its delay register spans one output period.
    always_ff @(posedge clock) begin
        if (reset) begin
            comb1  <= '0;
            comb2  <= '0;
            comb3  <= '0;
            prev1  <= '0;
            prev2  <= '0;
            prev3  <= '0;
            valid1 <= 1'b0;
            valid2 <= 1'b0;
            valid3 <= 1'b0;
        end else begin
            valid1 <= valid0;
            valid2 <= valid1;
            valid3 <= valid2;
            if (valid0) begin
                comb1 <= comb_in - prev1;
                prev1 <= comb_in;
            end
            if (valid1) begin
                comb2 <= comb1 - prev2;
                prev2 <= comb1;
            end
            if (valid2) begin
                comb3 <= comb2 - prev3;
                prev3 <= comb2;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.vout       <= '0;
            bus.vout_valid <= 1'b0;
        end else begin
            bus.vout_valid <= valid3;
            if (valid3) begin
                bus.vout <= comb3;
            end
        end
    end
endmodule

// File: tb/tb_dsm_rx_demod.sv
// Directed bench for dsm_rx_demod: hand-computed settled values and strobe timing,
// plus a closed-form CIC reference (triple running sum, third difference) for transients.
module tb_dsm_rx_demod;
    localparam int DECIM_LOG2 = 6;
    localparam int OUT_W      = 20;
    localparam int R          = 64;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    dsm_rx_demod_if #(.OUT_W(OUT_W)) bus ();

    dsm_rx_demod #(
        .DECIM_LOG2(DECIM_LOG2),
        .OUT_W     (OUT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    int     m_hist[$];
    longint s_hist[$];

    logic signed [OUT_W-1:0] exp_vout;
    logic                    exp_valid;
    logic                    exp_err;

    logic [1:0] pat_lo  [4] = '{2'b01, 2'b00, 2'b10, 2'b00};
    logic [1:0] pat_neg [4] = '{2'b10, 2'b00, 2'b01, 2'b00};

    function automatic int lo_weight(input int t);
        case ((t - 1) % 4)
            0:       return 1;
            2:       return -1;
            default: return 0;
        endcase
    endfunction

    function automatic int decode(input logic [1:0] p);
        case (p)
            2'b01:   return 1;
            2'b10:   return -1;
            default: return 0;
        endcase
    endfunction

    function automatic longint s_at(input int k);
        if (k < 1 || k > s_hist.size()) return 0;
        return s_hist[k-1];
    endfunction

    // Drives one symbol for cycle cyc+1 and advances the reference to match.
    // int3 latched at edge T equals sum_i m_i * C(T-2-i, 2).
    task automatic tick(input logic [1:0] p);
        longint s;
        longint n;
        longint d;
        int     k;
        bus.pwm = p;
        @(posedge clock);
        cyc++;
        m_hist.push_back(decode(p) * lo_weight(cyc));
        exp_err   = (p == 2'b11);
        exp_valid = 1'b0;
        if (cyc % R == 0) begin
            s = 0;
            for (int i = 1; i <= cyc - 4; i++) begin
                n = cyc - 2 - i;
                s += longint'(m_hist[i-1]) * (n * (n - 1) / 2);
            end
            s_hist.push_back(s);
        end
        if (cyc % R == 4 && cyc > R) begin
            k = s_hist.size();
            d = s_at(k) - 3 * s_at(k-1) + 3 * s_at(k-2) - s_at(k-3);
            exp_vout  = d[OUT_W-1:0];
            exp_valid = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.pwm = 2'b00;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        cyc       = 0;
        m_hist.delete();
        s_hist.delete();
        exp_vout  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus.vout !== 20'sd0) $display("[TB] FAIL reset_vout got %0d expected 0", bus.vout); else passed++;
        checks++;
        if (bus.vout_valid !== 1'b0) $display("[TB] FAIL reset_valid got %0b expected 0", bus.vout_valid); else passed++;
        checks++;
        if (bus.code_err !== 1'b0) $display("[TB] FAIL reset_code_err got %0b expected 0", bus.code_err); else passed++;
        do_reset();
    endtask

    task automatic test_zero_input();
        int first_valid = 0;
        int nval = 0;
        do_reset();
        for (int c = 0; c < 5 * R + 10; c++) begin
            tick(2'b00);
            if (bus.vout_valid === 1'b1) begin
                nval++;
                if (first_valid == 0) first_valid = cyc;
            end
            checks++;
            if ({bus.vout_valid, bus.code_err, bus.vout} !== {exp_valid, 1'b0, 20'sd0})
                $display("[TB] FAIL zero_cycle t=%0d got valid=%0b err=%0b vout=%0d expected valid=%0b err=0 vout=0",
                         cyc, bus.vout_valid, bus.code_err, bus.vout, exp_valid);
            else passed++;
        end
        checks++;
        if (first_valid !== 68) $display("[TB] FAIL zero_first_valid got %0d expected 68", first_valid); else passed++;
        checks++;
        if (nval !== 5) $display("[TB] FAIL zero_valid_count got %0d expected 5", nval); else passed++;
    endtask

    task automatic test_lo_pattern();
        int nval = 0;
        do_reset();
        for (int c = 0; c < 10 * R; c++) begin
            tick(pat_lo[cyc % 4]);
            checks++;
            if ({bus.vout_valid, bus.code_err, bus.vout} !== {exp_valid, exp_err, exp_vout})
                $display("[TB] FAIL lo_cycle t=%0d got valid=%0b err=%0b vout=%0d expected valid=%0b err=%0b vout=%0d",
                         cyc, bus.vout_valid, bus.code_err, bus.vout, exp_valid, exp_err, exp_vout);
            else passed++;
            if (bus.vout_valid === 1'b1) begin
                nval++;
                if (nval >= 4) begin
                    checks++;
                    if (bus.vout !== 20'sd131072)
                        $display("[TB] FAIL lo_settled n=%0d got %0d expected 131072", nval, bus.vout);
                    else passed++;
                end
            end
        end
        checks++;
        if (nval !== 9) $display("[TB] FAIL lo_valid_count got %0d expected 9", nval); else passed++;
    endtask

    task automatic test_dc_tone();
        int nval = 0;
        do_reset();
        for (int c = 0; c < 8 * R; c++) begin
            tick(2'b01);
            checks++;
            if ({bus.vout_valid, bus.vout} !== {exp_valid, exp_vout})
                $display("[TB] FAIL dc_cycle t=%0d got valid=%0b vout=%0d expected valid=%0b vout=%0d",
                         cyc, bus.vout_valid, bus.vout, exp_valid, exp_vout);
            else passed++;
            if (bus.vout_valid === 1'b1) begin
                nval++;
                if (nval >= 4) begin
                    checks++;
                    if (bus.vout !== 20'sd0)
                        $display("[TB] FAIL dc_settled n=%0d got %0d expected 0", nval, bus.vout);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_neg_long_run();
        int nval = 0;
        do_reset();
        for (int c = 0; c < 30000; c++) begin
            tick(pat_neg[cyc % 4]);
            checks++;
            if ({bus.vout_valid, bus.vout} !== {exp_valid, exp_vout})
                $display("[TB] FAIL neg_cycle t=%0d got valid=%0b vout=%0d expected valid=%0b vout=%0d",
                         cyc, bus.vout_valid, bus.vout, exp_valid, exp_vout);
            else passed++;
            if (bus.vout_valid === 1'b1) begin
                nval++;
                if (nval >= 4) begin
                    checks++;
                    if (bus.vout !== -20'sd131072)
                        $display("[TB] FAIL neg_settled n=%0d got %0d expected -131072", nval, bus.vout);
                    else passed++;
                end
            end
        end
        checks++;
        if (nval !== 468) $display("[TB] FAIL neg_valid_count got %0d expected 468", nval); else passed++;
    endtask

    task automatic test_code_err();
        do_reset();
        for (int c = 0; c < 5 * R; c++) begin
            tick((cyc == 199) ? 2'b11 : 2'b00);
            checks++;
            if ({bus.code_err, bus.vout} !== {(cyc == 200), 20'sd0})
                $display("[TB] FAIL code_err_cycle t=%0d got err=%0b vout=%0d expected err=%0b vout=0",
                         cyc, bus.code_err, bus.vout, (cyc == 200));
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        int first_valid = 0;
        int nval = 0;
        do_reset();
        while (cyc < 999) tick(pat_lo[cyc % 4]);
        do_reset();
        checks++;
        if ({bus.vout_valid, bus.code_err, bus.vout} !== {1'b0, 1'b0, 20'sd0})
            $display("[TB] FAIL mid_reset_clear got valid=%0b err=%0b vout=%0d expected all 0",
                     bus.vout_valid, bus.code_err, bus.vout);
        else passed++;
        for (int c = 0; c < 8 * R; c++) begin
            tick(pat_lo[cyc % 4]);
            checks++;
            if ({bus.vout_valid, bus.code_err, bus.vout} !== {exp_valid, exp_err, exp_vout})
                $display("[TB] FAIL mid_reset_cycle t=%0d got valid=%0b err=%0b vout=%0d expected valid=%0b err=%0b vout=%0d",
                         cyc, bus.vout_valid, bus.code_err, bus.vout, exp_valid, exp_err, exp_vout);
            else passed++;
            if (bus.vout_valid === 1'b1) begin
                nval++;
                if (first_valid == 0) first_valid = cyc;
                if (nval >= 4) begin
                    checks++;
                    if (bus.vout !== 20'sd131072)
                        $display("[TB] FAIL mid_reset_settled n=%0d got %0d expected 131072", nval, bus.vout);
                    else passed++;
                end
            end
        end
        checks++;
        if (first_valid !== 68) $display("[TB] FAIL mid_reset_first_valid got %0d expected 68", first_valid); else passed++;
    endtask

    initial begin
        reset     = 1'b1;
        bus.pwm   = 2'b00;
        exp_vout  = '0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        test_reset();
        test_zero_input();
        test_lo_pattern();
        test_dc_tone();
        test_code_err();
        test_mid_reset();
        test_neg_long_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
